// File: rtl/sobel_edge_pkg.sv
// Shared pixel/magnitude constants and kernel helpers for the Sobel edge stage.
package sobel_edge_pkg;

    localparam int PIX_W = 8;
    localparam int MAG_W = 11;
    localparam int SUM_W = MAG_W - 1;

    localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
    localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

    // One column of the 3x3 window: top is the oldest line, bot the current line.
    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } win_col_t;

    function automatic logic [SUM_W-1:0] tap121(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
        return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
    endfunction

    // |pos - neg| equals |Gx| or |Gy| without needing a signed intermediate.
    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel storage: simple dual-port RAM, registered read, read-before-write.
module sobel_line_buf
    import sobel_edge_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rd_data_q;

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sobel_edge.sv
// Sobel |Gx|+|Gy| edge detector with threshold; binary 0xFF/0x00 output, LAT clocks behind input.
module sobel_edge
    import sobel_edge_pkg::*;
#(
    parameter int COL = 640,
    parameter int ROW = 480,
    parameter int LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mid_vs,
    input  logic             mid_de,
    input  logic [PIX_W-1:0] mid_data,
    input  logic [9:0]       threshold,
    output logic             edge_vs,
    output logic             edge_de,
    output logic [PIX_W-1:0] edge_data
);

    localparam int CW = $clog2(COL);
    localparam int RW = $clog2(ROW);

    logic             vs_q, vs_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [9:0]       thr_q, thr_d;
    logic [LAT-1:0]   de_pipe_q, de_pipe_d;
    logic [LAT-1:0]   vs_pipe_q, vs_pipe_d;
    logic [LAT-2:0]   blank_pipe_q, blank_pipe_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [CW-1:0]    wr_col_q, wr_col_d;
    win_col_t         col1_q, col1_d, col2_q, col2_d, col3;
    logic [SUM_W-1:0] gx_pos_q, gx_pos_d, gx_neg_q, gx_neg_d;
    logic [SUM_W-1:0] gy_pos_q, gy_pos_d, gy_neg_q, gy_neg_d;
    logic [SUM_W-1:0] abs_gx_q, abs_gx_d, abs_gy_q, abs_gy_d;
    logic [PIX_W-1:0] edge_data_q, edge_data_d;

    logic             vs_rise;
    logic [CW-1:0]    pos_col;
    logic [RW-1:0]    pos_row;
    logic [MAG_W-1:0] mag;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    // lb1 is written one clock late because lb0's old value only appears after its registered read.
    sobel_line_buf #(.DEPTH(COL), .AW(CW)) u_lb0 (
        .clk     (clk),
        .wr_en   (mid_de),
        .wr_addr (pos_col),
        .wr_data (mid_data),
        .rd_en   (mid_de),
        .rd_addr (pos_col),
        .rd_data (lb0_rd)
    );

    sobel_line_buf #(.DEPTH(COL), .AW(CW)) u_lb1 (
        .clk     (clk),
        .wr_en   (de_pipe_q[0]),
        .wr_addr (wr_col_q),
        .wr_data (lb0_rd),
        .rd_en   (mid_de),
        .rd_addr (pos_col),
        .rd_data (lb1_rd)
    );

    always_comb begin
        vs_rise = mid_vs & ~vs_q;
        pos_col = vs_rise ? '0 : col_q;
        pos_row = vs_rise ? '0 : row_q;
        col3    = {lb1_rd, lb0_rd, pix_q};
        mag     = MAG_W'(abs_gx_q) + MAG_W'(abs_gy_q);

        vs_d  = mid_vs;
        col_d = pos_col;
        row_d = pos_row;
        thr_d = vs_rise ? threshold : thr_q;
        if (mid_de) begin
            if (pos_col == CW'(COL - 1)) begin
                col_d = '0;
                if (pos_row != RW'(ROW - 1)) begin
                    row_d = pos_row + 1'b1;
                end
            end else begin
                col_d = pos_col + 1'b1;
            end
        end

        de_pipe_d    = {de_pipe_q[LAT-2:0], mid_de};
        vs_pipe_d    = {vs_pipe_q[LAT-2:0], mid_vs};
        blank_pipe_d = {blank_pipe_q[LAT-3:0], (pos_row < RW'(2)) || (pos_col < CW'(2))};
        pix_d        = mid_de ? mid_data : pix_q;
        wr_col_d     = mid_de ? pos_col : wr_col_q;

        // The live RAM column acts as window column 3; the two older columns shift only on valid pixels.
        col1_d = col1_q;
        col2_d = col2_q;
        if (de_pipe_q[0]) begin
            col1_d = col2_q;
            col2_d = col3;
        end

        gx_pos_d = tap121(col3.top, col3.mid, col3.bot);
        gx_neg_d = tap121(col1_q.top, col1_q.mid, col1_q.bot);
        gy_pos_d = tap121(col1_q.bot, col2_q.bot, col3.bot);
        gy_neg_d = tap121(col1_q.top, col2_q.top, col3.top);

        abs_gx_d = abs_diff(gx_pos_q, gx_neg_q);
        abs_gy_d = abs_diff(gy_pos_q, gy_neg_q);

        edge_data_d = EDGE_OFF;
        if (de_pipe_q[LAT-2] && !blank_pipe_q[LAT-2] && (mag > {1'b0, thr_q})) begin
            edge_data_d = EDGE_ON;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q         <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            thr_q        <= '0;
            de_pipe_q    <= '0;
            vs_pipe_q    <= '0;
            blank_pipe_q <= '0;
            pix_q        <= '0;
            wr_col_q     <= '0;
            col1_q       <= '0;
            col2_q       <= '0;
            gx_pos_q     <= '0;
            gx_neg_q     <= '0;
            gy_pos_q     <= '0;
            gy_neg_q     <= '0;
            abs_gx_q     <= '0;
            abs_gy_q     <= '0;
            edge_data_q  <= '0;
        end else begin
            vs_q         <= vs_d;
            col_q        <= col_d;
            row_q        <= row_d;
            thr_q        <= thr_d;
            de_pipe_q    <= de_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
            blank_pipe_q <= blank_pipe_d;
            pix_q        <= pix_d;
            wr_col_q     <= wr_col_d;
            col1_q       <= col1_d;
            col2_q       <= col2_d;
            gx_pos_q     <= gx_pos_d;
            gx_neg_q     <= gx_neg_d;
            gy_pos_q     <= gy_pos_d;
            gy_neg_q     <= gy_neg_d;
            abs_gx_q     <= abs_gx_d;
            abs_gy_q     <= abs_gy_d;
            edge_data_q  <= edge_data_d;
        end
    end

    assign edge_de   = de_pipe_q[LAT-1];
    assign edge_vs   = vs_pipe_q[LAT-1];
    assign edge_data = edge_data_q;

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge on an 8x6 frame: flat, step, threshold and reset cases.
module tb_sobel_edge;

    localparam int COL = 8;
    localparam int ROW = 6;
    localparam int LAT = 4;
    localparam int NPIX = COL * ROW;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mid_vs = 1'b0;
    logic       mid_de = 1'b0;
    logic [7:0] mid_data = 8'h00;
    logic [9:0] threshold = 10'd100;
    logic       edge_vs;
    logic       edge_de;
    logic [7:0] edge_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] out_q[$];
    int  neg_cyc = 0;
    int  first_de_cyc = -1;
    int  first_out_cyc = -1;
    int  first_vs_cyc = -1;
    int  first_evs_cyc = -1;
    bit  check_delay = 1'b0;
    bit  check_quiet = 1'b0;
    logic [3:0] de_hist = '0;

    sobel_edge #(.COL(COL), .ROW(ROW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .mid_vs    (mid_vs),
        .mid_de    (mid_de),
        .mid_data  (mid_data),
        .threshold (threshold),
        .edge_vs   (edge_vs),
        .edge_de   (edge_de),
        .edge_data (edge_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        mid_de = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor, sampled on the falling edge away from DUT updates.
    initial begin
        forever begin
            @(negedge clk);
            neg_cyc++;
            if (rst && check_quiet) begin
                checkOutput("rst_de", 32'(edge_de), 32'd0);
                checkOutput("rst_vs", 32'(edge_vs), 32'd0);
                checkOutput("rst_data", 32'(edge_data), 32'd0);
            end
            if (mid_de && first_de_cyc < 0) first_de_cyc = neg_cyc;
            if (edge_de && first_out_cyc < 0) first_out_cyc = neg_cyc;
            if (mid_vs && first_vs_cyc < 0) first_vs_cyc = neg_cyc;
            if (edge_vs && first_evs_cyc < 0) first_evs_cyc = neg_cyc;
            if (edge_de) out_q.push_back(edge_data);
            if (check_delay) checkOutput("de_delay", 32'(edge_de), 32'(de_hist[3]));
            de_hist = {de_hist[2:0], mid_de};
        end
    end

    // kind 0 = flat 0x80, kind 1 = vertical step 0 | step_val at column 4.
    task automatic applyStimulus(input int kind, input logic [7:0] step_val, input bit gaps,
                                 input bit vs_on_de, input int thr_idx, input logic [9:0] thr_val,
                                 input int rst_idx);
        out_q.delete();
        if (!vs_on_de) begin
            mid_vs = 1'b1;
            idle(2);
            mid_vs = 1'b0;
            idle(2);
        end
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                int idx;
                idx = r * COL + c;
                if (idx == thr_idx) threshold = thr_val;
                if (idx == rst_idx) begin
                    rst = 1'b1;
                    check_quiet = 1'b1;
                    idle(2);
                    rst = 1'b0;
                    check_quiet = 1'b0;
                    idle(4);
                    return;
                end
                if (gaps) idle(int'($urandom_range(3)));
                mid_de   = 1'b1;
                mid_data = (kind == 0) ? 8'h80 : ((c < 4) ? 8'h00 : step_val);
                mid_vs   = vs_on_de && (idx < 2);
                @(posedge clk);
                #1;
                mid_de = 1'b0;
                mid_vs = 1'b0;
            end
        end
        idle(8);
    endtask

    // Step edges land at output columns 4 and 5 from row 2 on; everything else is 0x00.
    task automatic checkFrame(input bit step_edges, input string name);
        logic [7:0] exp;
        checkOutput({name, "_count"}, out_q.size(), NPIX);
        for (int i = 0; i < NPIX && i < out_q.size(); i++) begin
            int r;
            int c;
            r = i / COL;
            c = i % COL;
            exp = (step_edges && r >= 2 && (c == 4 || c == 5)) ? 8'hFF : 8'h00;
            checkOutput($sformatf("%s_r%0dc%0d", name, r, c), 32'(out_q[i]), 32'(exp));
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_de", 32'(edge_de), 32'd0);
        checkOutput("reset_vs", 32'(edge_vs), 32'd0);
        checkOutput("reset_data", 32'(edge_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        applyStimulus(0, 8'h00, 1'b0, 1'b0, -1, 10'd0, -1);
        checkFrame(1'b0, "flat");
        checkOutput("de_latency", first_out_cyc - first_de_cyc, 32'd4);
        checkOutput("vs_latency", first_evs_cyc - first_vs_cyc, 32'd4);

        applyStimulus(1, 8'd200, 1'b0, 1'b0, -1, 10'd0, -1);
        checkFrame(1'b1, "step");

        applyStimulus(1, 8'd25, 1'b0, 1'b0, -1, 10'd0, -1);
        checkFrame(1'b0, "eq_thr");

        threshold = 10'd99;
        applyStimulus(1, 8'd25, 1'b0, 1'b1, -1, 10'd0, -1);
        checkFrame(1'b1, "thr99");

        threshold = 10'd100;
        check_delay = 1'b1;
        applyStimulus(1, 8'd200, 1'b1, 1'b0, -1, 10'd0, -1);
        check_delay = 1'b0;
        checkFrame(1'b1, "gaps");

        applyStimulus(1, 8'd200, 1'b0, 1'b0, 20, 10'd1000, -1);
        checkFrame(1'b1, "thr_hold");
        applyStimulus(1, 8'd200, 1'b0, 1'b0, -1, 10'd0, -1);
        checkFrame(1'b0, "thr_new");

        threshold = 10'd100;
        applyStimulus(1, 8'd200, 1'b0, 1'b0, -1, 10'd0, 29);
        applyStimulus(1, 8'd200, 1'b0, 1'b0, -1, 10'd0, -1);
        checkFrame(1'b1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
